// File: rtl/uart_pixel_loader.sv
// rtl/uart_pixel_loader.sv - Avalon-MM UART poller packing RX bytes into words behind a show-ahead FIFO
module uart_pixel_loader #(
    parameter int BYTES_PER_WORD = 3,
    parameter int MSB_FIRST      = 0,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int RX_BASE        = 0,
    parameter int STATUS_BASE    = 8,
    parameter int RX_OK_BIT      = 7
) (
    input  logic                          avm_clk,
    input  logic                          avm_rst,
    output logic [4:0]                    avm_address,
    output logic                          avm_read,
    input  logic [31:0]                   avm_readdata,
    input  logic                          avm_waitrequest,
    output logic [8*BYTES_PER_WORD-1:0]   o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_resync
);
    localparam int DW = 8 * BYTES_PER_WORD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX    = IW'(BYTES_PER_WORD - 1);
    localparam logic [TW-1:0] TO_LIMIT    = TW'(TIMEOUT_CYCLES);
    localparam logic [4:0]    RX_ADDR     = 5'(RX_BASE);
    localparam logic [4:0]    STATUS_ADDR = 5'(STATUS_BASE);
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_GAP, S_POLL, S_READ} state_t;

    state_t          state_q, state_d;
    logic            rx_next_q, rx_next_d;
    logic            read_q;
    logic [4:0]      addr_q;
    logic [IW-1:0]   byte_idx_q, byte_idx_d;
    logic [IW-1:0]   lane;
    logic [DW-1:0]   word_q, word_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            resync_q, resync_d;

    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_after_pop;
    logic [DW-1:0]   last_pop_q;

    logic            acc, rx_acc, push, pop;
    logic            unused_rd;

    assign unused_rd       = ^avm_readdata;
    assign acc             = read_q && !avm_waitrequest;
    assign rx_acc          = acc && (state_q == S_READ);
    assign pop             = (level_q != '0) && i_ready;
    assign level_after_pop = level_q - LW'(pop);

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign o_valid     = (level_q != '0);
    assign o_level     = level_q;
    assign o_data      = o_valid ? mem_q[rd_ptr_q] : last_pop_q;
    assign o_resync    = resync_q;

    // A pending READ always proceeds; only fresh polls are gated by FIFO space.
    always_comb begin
        state_d   = state_q;
        rx_next_d = rx_next_q;
        unique case (state_q)
            S_GAP: begin
                if (rx_next_q) begin
                    state_d = S_READ;
                end else if (level_after_pop < FULL_LEVEL) begin
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                if (acc) begin
                    state_d   = S_GAP;
                    rx_next_d = avm_readdata[RX_OK_BIT];
                end
            end
            S_READ: begin
                if (acc) begin
                    state_d   = S_GAP;
                    rx_next_d = 1'b0;
                end
            end
            default: state_d = S_GAP;
        endcase
    end

    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        to_cnt_d   = to_cnt_q;
        resync_d   = 1'b0;
        push       = 1'b0;
        lane       = (MSB_FIRST != 0) ? (LAST_IDX - byte_idx_q) : byte_idx_q;
        if (rx_acc) begin
            word_d[8*int'(lane) +: 8] = avm_readdata[7:0];
            if (byte_idx_q == LAST_IDX) begin
                push       = 1'b1;
                byte_idx_d = '0;
            end else begin
                byte_idx_d = byte_idx_q + IW'(1);
            end
        end
        // An accepted byte in the expiry cycle takes priority over the discard.
        if (TIMEOUT_CYCLES > 0) begin
            if (rx_acc || (byte_idx_q == '0)) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LIMIT) begin
                to_cnt_d   = '0;
                byte_idx_d = '0;
                resync_d   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state_q    <= S_GAP;
            rx_next_q  <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= STATUS_ADDR;
            byte_idx_q <= '0;
            word_q     <= '0;
            to_cnt_q   <= '0;
            resync_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_next_q  <= rx_next_d;
            read_q     <= (state_d != S_GAP);
            addr_q     <= (state_d == S_READ) ? RX_ADDR : STATUS_ADDR;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            to_cnt_q   <= to_cnt_d;
            resync_q   <= resync_d;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_d;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            last_pop_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                last_pop_q <= mem_q[rd_ptr_q];
            end
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end
endmodule

// File: tb/tb_uart_pixel_loader.sv
// tb/tb_uart_pixel_loader.sv - randomized Avalon slave plus word/FIFO reference model for uart_pixel_loader
module tb_uart_pixel_loader;
    localparam int BPW = 3, DEPTH = 4, TO = 20, STATUS = 8, RXB = 0, OKB = 7;

    logic        clk = 1'b0;
    logic        avm_rst = 1'b1, avm_read, avm_waitrequest = 1'b0, i_ready = 1'b0;
    logic [4:0]  avm_address;
    logic [31:0] avm_readdata = '0;
    logic [23:0] o_data;
    logic        o_valid, o_resync;
    logic [2:0]  o_level;

    logic        avm_rst1 = 1'b1, avm_read1, avm_waitrequest1 = 1'b0;
    logic [4:0]  avm_address1;
    logic [31:0] avm_readdata1 = '0;
    logic [31:0] o_data1;
    logic        o_valid1, o_resync1;
    logic [2:0]  o_level1;

    always #5 clk = ~clk;

    uart_pixel_loader #(.BYTES_PER_WORD(BPW), .MSB_FIRST(0), .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO), .RX_BASE(RXB), .STATUS_BASE(STATUS), .RX_OK_BIT(OKB)) dut (
        .avm_clk(clk), .avm_rst(avm_rst), .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_level(o_level), .o_resync(o_resync));

    uart_pixel_loader #(.BYTES_PER_WORD(4), .MSB_FIRST(1), .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(0), .RX_BASE(0), .STATUS_BASE(8), .RX_OK_BIT(7)) dut1 (
        .avm_clk(clk), .avm_rst(avm_rst1), .avm_address(avm_address1), .avm_read(avm_read1),
        .avm_readdata(avm_readdata1), .avm_waitrequest(avm_waitrequest1),
        .o_data(o_data1), .o_valid(o_valid1), .i_ready(1'b0), .o_level(o_level1), .o_resync(o_resync1));

    int checks = 0, errors = 0;

    // Stimulus controls, written by the main sequence and read by the slave/model process.
    bit rst_v = 1'b1, ready_v = 1'b0, rand_ready = 1'b0, rand_wait = 1'b0, hold_rx = 1'b0;
    int hold_until = 0, zero_cnt = 0;
    logic [7:0] rxq [$];

    int cyc = 0, n_stat = 0, n_rx = 0, n_resync = 0, last_rx_cyc = 0, stat_at_rx = 0;

    logic [23:0] mfifo [$];
    logic [7:0]  mpart [$];
    logic [23:0] mlast = '0, exp_data, w;
    int          mlast_acc = 0, cnt = 0, wait_left = 0, k1 = 0;
    bit          m_exp_rx = 0, resync_exp = 0, rs_next;
    bit          prev_read = 0, prev_wait = 0, prev_acc = 0, first_after = 1;
    bit          new_acc, is_rx, ok, wr, acc, prev_r1 = 0, prev_w1 = 0, wr1;
    logic [4:0]  prev_addr = '0, prev_a1 = '0;
    logic [31:0] rd;
    logic [7:0]  d1 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rx(input int target);
        for (int i = 0; i < 400 && n_rx < target; i++) tick(1);
        chk("wait_rx", n_rx >= target, 1);
    endtask

    task automatic wait_level(input int lvl);
        for (int i = 0; i < 800 && int'(o_level) != lvl; i++) tick(1);
        chk("wait_level", o_level, lvl);
    endtask

    // Avalon slave, reference model and per-cycle compare, all on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            avm_rst  = rst_v;
            avm_rst1 = rst_v;
            i_ready  = rand_ready ? 1'($urandom_range(0, 1)) : ready_v;
            if (rst_v) begin
                avm_waitrequest  = 1'b0;
                avm_waitrequest1 = 1'b0;
                mfifo.delete(); mpart.delete();
                mlast = '0; m_exp_rx = 0; resync_exp = 0;
                prev_read = 0; prev_wait = 0; prev_acc = 0; first_after = 1; wait_left = 0;
                k1 = 0; prev_r1 = 0; prev_w1 = 0;
                continue;
            end
            cnt     = mfifo.size();
            new_acc = avm_read && !(prev_read && prev_wait);
            if (new_acc) wait_left = rand_wait ? int'($urandom_range(0, 3)) : 0;
            is_rx = (avm_address == 5'(RXB));
            ok    = (rxq.size() > 0) && (zero_cnt == 0);
            wr    = avm_read && ((wait_left > 0) || (is_rx && (hold_rx || cyc < hold_until)));
            if (avm_read && wait_left > 0) wait_left--;
            avm_waitrequest = wr;
            rd = $urandom;
            if (is_rx) begin
                if (rxq.size() > 0) rd[7:0] = rxq[0];
            end else begin
                rd[OKB] = ok;
            end
            avm_readdata = rd;
            acc = avm_read && !wr;

            if (prev_acc) chk("gap_after_accept", avm_read, 0);
            if (prev_read && prev_wait) begin
                chk("stall_hold", {avm_read, avm_address}, {1'b1, prev_addr});
            end else if (new_acc) begin
                chk("access_addr", avm_address, m_exp_rx ? RXB : STATUS);
                if (!m_exp_rx) chk("poll_not_full", cnt < DEPTH, 1);
            end else if (!avm_read && !prev_read && !first_after) begin
                chk("gap_len", (cnt == DEPTH) && !m_exp_rx, 1);
            end

            exp_data = mlast;
            if (cnt > 0) exp_data = mfifo[0];
            chk("o_level", o_level, cnt);
            chk("o_valid", o_valid, cnt != 0);
            chk("o_data", o_data, exp_data);
            chk("o_resync", o_resync, resync_exp);
            if (o_resync) n_resync++;

            if (i_ready && cnt > 0) mlast = mfifo.pop_front();
            rs_next = 0;
            if (acc && !is_rx) begin
                n_stat++;
                m_exp_rx = ok;
                if (zero_cnt > 0) zero_cnt--;
            end
            if (acc && is_rx) begin
                n_rx++;
                last_rx_cyc = cyc;
                stat_at_rx  = n_stat;
                mpart.push_back((rxq.size() > 0) ? rxq.pop_front() : 8'h00);
                mlast_acc = cyc;
                m_exp_rx  = 0;
                if (mpart.size() == BPW) begin
                    w = '0;
                    for (int i = 0; i < BPW; i++) w[8*i +: 8] = mpart[i];
                    mfifo.push_back(w);
                    mpart.delete();
                end
            end else if (mpart.size() > 0 && cyc - mlast_acc == TO + 1) begin
                mpart.delete();
                rs_next = 1;
            end
            resync_exp  = rs_next;
            prev_acc    = acc;
            prev_read   = avm_read;
            prev_wait   = wr;
            prev_addr   = avm_address;
            first_after = 0;

            wr1 = avm_read1 && ($urandom_range(0, 1) == 1);
            avm_waitrequest1 = wr1;
            if (avm_address1 == 5'd8) avm_readdata1 = (k1 < 4) ? 32'h80 : 32'h0;
            else if (k1 < 4)          avm_readdata1 = {24'h0, d1[k1]};
            else                      avm_readdata1 = 32'h0;
            if (prev_r1 && prev_w1) chk("u1_stall_hold", {avm_read1, avm_address1}, {1'b1, prev_a1});
            if (avm_read1 && !wr1 && avm_address1 == 5'd0) k1++;
            prev_r1 = avm_read1;
            prev_w1 = wr1;
            prev_a1 = avm_address1;
        end
    end

    initial begin
        int s0, rs0, r0;
        tick(3);
        chk("rst_read", avm_read, 0);
        chk("rst_address", avm_address, STATUS);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_level", o_level, 0);
        chk("rst_resync", o_resync, 0);
        rst_v = 0;
        tick(1);
        chk("first_read", avm_read, 1);

        rxq.push_back(8'h11); rxq.push_back(8'h22); rxq.push_back(8'h33);
        for (int i = 0; i < 100 && !o_valid; i++) tick(1);
        chk("word_332211", o_data, 24'h332211);
        chk("valid_latency", cyc - last_rx_cyc, 0);
        chk("three_bytes", n_rx, 3);

        for (int i = 0; i < 300 && !o_valid1; i++) tick(1);
        chk("u1_deadbeef", o_data1, 32'hDEADBEEF);

        ready_v = 1; wait_level(0); ready_v = 0;

        s0 = n_stat; zero_cnt = 5; rxq.push_back(8'h44);
        wait_rx(4);
        chk("status_polls", stat_at_rx - s0, 6);
        rs0 = n_resync;
        tick(40);
        chk("partial_timeout", n_resync - rs0, 1);

        for (int b = 1; b <= 15; b++) rxq.push_back(8'(b));
        wait_level(4);
        r0 = n_stat;
        tick(30);
        chk("full_level", o_level, 4);
        chk("full_no_poll", n_stat - r0, 0);
        chk("full_read_low", avm_read, 0);
        ready_v = 1; tick(1); ready_v = 0;
        chk("one_pop_level", o_level, 3);
        wait_level(4);
        chk("no_lost_byte", rxq.size(), 0);
        ready_v = 1; wait_level(0); ready_v = 0;

        rs0 = n_resync;
        rxq.push_back(8'h55); rxq.push_back(8'h66);
        wait_rx(n_rx + 2);
        tick(40);
        chk("resync_once", n_resync - rs0, 1);
        rxq.push_back(8'hA1); rxq.push_back(8'hB2); rxq.push_back(8'hC3);
        for (int i = 0; i < 100 && !o_valid; i++) tick(1);
        chk("word_c3b2a1", o_data, 24'hC3B2A1);
        ready_v = 1; wait_level(0); ready_v = 0;

        rs0 = n_resync;
        rxq.push_back(8'h77);
        wait_rx(n_rx + 1);
        hold_until = last_rx_cyc + TO + 1;
        rxq.push_back(8'h88);
        wait_rx(n_rx + 1);
        chk("exact_cycle", last_rx_cyc, hold_until);
        tick(5);
        chk("no_resync_exact", n_resync - rs0, 0);
        rxq.push_back(8'h99);
        wait_level(1);
        chk("word_998877", o_data, 24'h998877);

        rxq.push_back(8'h12);
        wait_rx(n_rx + 1);
        hold_until = last_rx_cyc + TO + 2;
        rxq.push_back(8'h34);
        wait_rx(n_rx + 1);
        tick(5);
        chk("resync_late", n_resync - rs0, 1);
        rxq.push_back(8'h56); rxq.push_back(8'h78);
        wait_level(2);
        ready_v = 1; wait_level(0); ready_v = 0;

        rand_wait = 1; rand_ready = 1;
        for (int k = 0; k < 150; k++) begin
            if (rxq.size() < 4) begin
                repeat ($urandom_range(1, 5)) rxq.push_back(8'($urandom));
            end
            if ($urandom_range(0, 7) == 0) zero_cnt = $urandom_range(1, 3);
            tick($urandom_range(1, 8));
            if ($urandom_range(0, 11) == 0) tick(30);
        end
        for (int i = 0; i < 3000 && rxq.size() > 0; i++) tick(1);
        chk("random_drained", rxq.size(), 0);
        tick(40);
        rand_wait = 0; rand_ready = 0;

        rst_v = 1; tick(2); rst_v = 0; tick(2);
        for (int b = 0; b < 6; b++) rxq.push_back(8'($urandom));
        wait_level(2);
        hold_rx = 1;
        rxq.push_back(8'hEE);
        for (int i = 0; i < 100 && !(avm_read && avm_address == 5'(RXB)); i++) tick(1);
        chk("read_stalled", {avm_read, avm_address}, {1'b1, 5'(RXB)});
        tick(2);
        rst_v = 1; tick(1);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_level", o_level, 0);
        chk("midrst_read", avm_read, 0);
        chk("midrst_address", avm_address, STATUS);
        rst_v = 0; hold_rx = 0; rxq.delete();
        tick(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
